aes_block_loader: RTL and testbench

- Byte-stream front end for the AES encrypt/decrypt datapath.
- Collects a framed byte stream (header, optional 16-byte key, 16-byte data block) into 128-bit key and data words plus a mode bit.
- Presents them on a valid/ready output to the stage that selects ciphertext or plaintext.
- Keeps the last committed key across frames, so a session key is loaded once.

---
 rtl/aes_block_loader_if.sv | 32 +++
 rtl/aes_block_loader.sv | 199 +++++++++++++++++++
 tb/tb_aes_block_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if
//   Bundles the byte-stream input handshake and the assembled-block output
//   handshake of aes_block_loader.
//   master : the loader side (consumes the byte stream, produces blocks)
//   slave  : the environment side (drives bytes, consumes blocks)
//   Signals: in_byte/in_valid/in_ready    byte stream
//            blk_data/blk_key/blk_mode    assembled block, key and mode
//            blk_valid/blk_ready          block handshake
//            key_valid                    a key has been committed
//            frame_err                    one-cycle pulse on timeout abort
interface aes_block_loader_if;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] blk_data;
  logic [127:0] blk_key;
  logic         blk_mode;
  logic         blk_valid;
  logic         blk_ready;
  logic         key_valid;
  logic         frame_err;

  modport master (
    input  in_byte, in_valid, blk_ready,
    output in_ready, blk_data, blk_key, blk_mode, blk_valid, key_valid, frame_err
  );

  modport slave (
    output in_byte, in_valid, blk_ready,
    input  in_ready, blk_data, blk_key, blk_mode, blk_valid, key_valid, frame_err
  );
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Byte-stream front end for the AES datapath. Collects a frame made of a
//   header byte (bit0 = mode, bit1 = key present), an optional 16-byte key
//   and a 16-byte data block into 128-bit words in column-major state order
//   (byte k lands in bits [127-8k -: 8]). The last committed key is kept
//   across frames. An idle gap of TIMEOUT_CYCLES inside a frame aborts it.
//   Ports: clk, rst (async, active-high); bus (aes_block_loader_if.master)
//   carrying the byte stream handshake and the block output handshake.
module aes_block_loader #(
  parameter int unsigned  TIMEOUT_CYCLES = 1000000,
  parameter logic [127:0] KEY_RESET      = 128'h0
) (
  input logic                clk,
  input logic                rst,
  aes_block_loader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Counter is wide enough to hold TIMEOUT_CYCLES-1 with margin, never narrower than 2 bits.
  localparam int unsigned   TW          = $clog2(TIMEOUT_CYCLES + 2) + 1;
  localparam int unsigned   TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LAST     = TW'(TO_LAST_INT);
  localparam logic          TO_EN       = (TIMEOUT_CYCLES > 0);

  // Replace byte slot idx of a 128-bit word; slot 0 is the most significant byte.
  function automatic logic [127:0] put_byte(input logic [127:0] word,
                                            input logic [3:0]   idx,
                                            input logic [7:0]   b);
    logic [127:0] r;
    logic [6:0]   top;
    r = word;
    top = 7'd127 - {idx, 3'b000};
    r[top -: 8] = b;
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [3:0]    cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic          mode_pend_r;
  logic [127:0]  key_stage_r;
  logic [127:0]  blk_data_r;
  logic [127:0]  blk_key_r;
  logic          blk_mode_r;
  logic          blk_valid_r;
  logic          key_valid_r;
  logic          frame_err_r;

  logic          xfer_s;
  logic          cnt_last_s;
  logic          in_frame_s;
  logic          timeout_s;
  logic [127:0]  key_merged_s;
  logic          key_commit_s;
  logic          blk_load_s;
  logic          abort_s;
  logic          out_done_s;

  assign bus.in_ready  = (state_r != OUT);
  assign xfer_s        = bus.in_valid && (state_r != OUT);
  assign cnt_last_s    = (cnt_r == 4'd15);
  assign in_frame_s    = (state_r == KEY) || (state_r == DATA);
  // A transfer always beats the timeout in the same cycle.
  assign timeout_s     = TO_EN && in_frame_s && !xfer_s && (to_cnt_r == TO_LAST);
  // Final key byte is merged combinationally so the commit is a single edge.
  assign key_merged_s  = put_byte(key_stage_r, cnt_r, bus.in_byte);

  assign bus.blk_data  = blk_data_r;
  assign bus.blk_key   = blk_key_r;
  assign bus.blk_mode  = blk_mode_r;
  assign bus.blk_valid = blk_valid_r;
  assign bus.key_valid = key_valid_r;
  assign bus.frame_err = frame_err_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle commit strobes.
  always_comb begin
    state_s      = state_r;
    key_commit_s = 1'b0;
    blk_load_s   = 1'b0;
    abort_s      = 1'b0;
    out_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_s = bus.in_byte[1] ? KEY : DATA;
        end else begin
          state_s = IDLE;
        end
      end
      KEY: begin
        if (xfer_s && cnt_last_s) begin
          state_s      = DATA;
          key_commit_s = 1'b1;
        end else if (timeout_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = KEY;
        end
      end
      DATA: begin
        if (xfer_s && cnt_last_s) begin
          state_s    = OUT;
          blk_load_s = 1'b1;
        end else if (timeout_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = DATA;
        end
      end
      OUT: begin
        if (blk_valid_r && bus.blk_ready) begin
          state_s    = IDLE;
          out_done_s = 1'b1;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte slot counter and inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= 4'd0;
      to_cnt_r <= '0;
    end else begin
      if (in_frame_s && xfer_s) begin
        cnt_r <= cnt_last_s ? 4'd0 : cnt_r + 4'd1;
      end else if ((state_r == IDLE) || abort_s) begin
        cnt_r <= 4'd0;
      end else begin
        cnt_r <= cnt_r;
      end
      if (TO_EN && in_frame_s && !xfer_s && !abort_s) begin
        to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  // Header, key staging/commit, data assembly and output handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_pend_r <= 1'b0;
      key_stage_r <= 128'h0;
      blk_data_r  <= 128'h0;
      blk_key_r   <= KEY_RESET;
      blk_mode_r  <= 1'b0;
      blk_valid_r <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= abort_s;
      if ((state_r == IDLE) && xfer_s) begin
        mode_pend_r <= bus.in_byte[0];
      end
      if ((state_r == KEY) && xfer_s) begin
        key_stage_r <= key_merged_s;
      end else if (abort_s) begin
        key_stage_r <= 128'h0;
      end
      if (key_commit_s) begin
        blk_key_r   <= key_merged_s;
        key_valid_r <= 1'b1;
      end
      if ((state_r == DATA) && xfer_s) begin
        blk_data_r <= put_byte(blk_data_r, cnt_r, bus.in_byte);
      end
      if (blk_load_s) begin
        blk_mode_r  <= mode_pend_r;
        blk_valid_r <= 1'b1;
      end else if (out_done_s) begin
        blk_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader
//   Directed and randomized frames against a frame-level reference model:
//   expected key/data words are built by shifting bytes in arrival order,
//   the mode comes from the header, and timeouts/resets update the model.
module tb_aes_block_loader;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_block_loader_if bif();

  aes_block_loader #(.TIMEOUT_CYCLES(TO), .KEY_RESET(128'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_key;
  logic [127:0] exp_data;
  logic         exp_kv;
  logic         exp_mode;
  logic [7:0]   key_bytes  [16];
  logic [7:0]   data_bytes [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_key  = 128'h0;
    exp_data = 128'h0;
    exp_kv   = 1'b0;
    exp_mode = 1'b0;
  endtask

  // Compare every output against the model; blk_valid and in_ready given by caller.
  task automatic chk_all(input string tag, input logic vld);
    chk({tag, "_blk_valid"}, 128'(bif.blk_valid), 128'(vld));
    chk({tag, "_in_ready"},  128'(bif.in_ready),  128'(!vld));
    chk({tag, "_blk_data"},  bif.blk_data, exp_data);
    chk({tag, "_blk_key"},   bif.blk_key,  exp_key);
    chk({tag, "_blk_mode"},  128'(bif.blk_mode),  128'(exp_mode));
    chk({tag, "_key_valid"}, 128'(bif.key_valid), 128'(exp_kv));
  endtask

  // Asynchronous reset applied away from any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag, 1'b0);
    chk({tag, "_frame_err"}, 128'(bif.frame_err), 128'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One byte transfer preceded by gap idle cycles; returns 1 time unit after the edge.
  task automatic xfer(input logic [7:0] b, input int gap);
    bif.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bif.in_byte   = b;
    bif.in_valid  = 1'b1;
    bif.blk_ready = 1'($urandom_range(0, 1));
    chk("in_ready_at_drive", 128'(bif.in_ready), 128'h1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] hdr, input int maxgap, input int hold);
    logic [127:0] k;
    logic [127:0] d;
    int start;
    k = 128'h0;
    d = 128'h0;
    xfer(hdr, $urandom_range(0, maxgap));
    start = cyc;
    if (hdr[1]) begin
      for (int i = 0; i < 16; i++) begin
        xfer(key_bytes[i], $urandom_range(0, maxgap));
        k = {k[119:0], key_bytes[i]};
        if (i < 15) begin
          chk("key_valid_before_commit", 128'(bif.key_valid), 128'(exp_kv));
        end else begin
          exp_key = k;
          exp_kv  = 1'b1;
          chk("key_commit_blk_key", bif.blk_key, exp_key);
          chk("key_commit_key_valid", 128'(bif.key_valid), 128'h1);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      xfer(data_bytes[i], $urandom_range(0, maxgap));
      d = {d[119:0], data_bytes[i]};
      if (i < 15) begin
        chk("blk_valid_early", 128'(bif.blk_valid), 128'h0);
      end
    end
    exp_data = d;
    exp_mode = hdr[0];
    if (maxgap == 0) begin
      chk("latency_cycles", 128'(cyc - start), hdr[1] ? 128'd32 : 128'd16);
    end
    chk_all("block_out", 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bif.in_valid  = 1'b1;
      bif.in_byte   = 8'($urandom);
      bif.blk_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_all("out_hold", 1'b1);
    end
    @(negedge clk);
    bif.in_valid  = 1'b0;
    bif.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.blk_ready = 1'b0;
    chk_all("after_handshake", 1'b0);
  endtask

  // Stall inside a frame and expect exactly one frame_err pulse after TO idle cycles.
  task automatic stall_abort(input string tag);
    for (int i = 0; i < int'(TO) - 1; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_no_err_yet"}, 128'(bif.frame_err), 128'h0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_err_pulse"}, 128'(bif.frame_err), 128'h1);
    chk_all(tag, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_err_single"}, 128'(bif.frame_err), 128'h0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.in_byte   = 8'h00;
    bif.in_valid  = 1'b0;
    bif.blk_ready = 1'b0;
    model_reset();
    #1;
    do_reset("reset");

    // Data-only encrypt frame right after reset: key stays at reset value.
    for (int i = 0; i < 16; i++) data_bytes[i] = 8'($urandom);
    run_frame(8'h01, 0, 0);

    // Keyed encrypt frame from the reference vectors.
    for (int i = 0; i < 16; i++) begin
      key_bytes[i]  = 8'(i);
      data_bytes[i] = 8'(i * 17);
    end
    run_frame(8'h03, 0, 0);
    chk("vector_key",  bif.blk_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("vector_data", exp_data,    128'h00112233445566778899aabbccddeeff);

    // Decrypt frame reusing the session key, with a long consumer stall.
    for (int i = 0; i < 16; i++) data_bytes[i] = 8'(255 - i * 17);
    run_frame(8'h00, 0, 10);
    chk("vector2_key",  bif.blk_key,  128'h000102030405060708090a0b0c0d0e0f);
    chk("vector2_data", bif.blk_data, 128'hffeeddccbbaa99887766554433221100);

    // Timeout during DATA: partial write visible, key preserved.
    xfer(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      data_bytes[i] = 8'($urandom);
      xfer(data_bytes[i], 0);
    end
    exp_data = {data_bytes[0], data_bytes[1], data_bytes[2], exp_data[103:0]};
    stall_abort("data_timeout");

    // Timeout during KEY from reset: nothing committed.
    do_reset("reset2");
    xfer(8'h02, 0);
    for (int i = 0; i < 5; i++) xfer(8'($urandom), 0);
    stall_abort("key_timeout");
    for (int i = 0; i < 16; i++) begin
      key_bytes[i]  = 8'($urandom);
      data_bytes[i] = 8'($urandom);
    end
    run_frame(8'h03, 2, 2);

    // Reset in the middle of DATA, then a clean frame with no stale bytes.
    xfer(8'h00, 0);
    for (int i = 0; i < 9; i++) xfer(8'($urandom), 0);
    #2;
    do_reset("mid_reset");
    for (int i = 0; i < 16; i++) data_bytes[i] = 8'($urandom);
    run_frame(8'h01, 0, 1);

    // Randomized frames with gaps shorter than the timeout and random header padding bits.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) begin
        key_bytes[i]  = 8'($urandom);
        data_bytes[i] = 8'($urandom);
      end
      run_frame(8'($urandom), 3, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
